// File: rtl/w_clk_ctrl_prog.sv
// Write-domain control for the asynchronous FIFO.
// Produces the Gray write pointer and binary RAM address, and brings the read
// pointer across through a flop chain. Also keeps a registered fill level, a
// programmable almost-full flag and a sticky overflow flag.
module w_clk_ctrl_prog #(
    parameter int ADDRESS_SIZE = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    w_clk,
    input  logic                    wrst_n,
    input  logic                    w_en,
    input  logic [ADDRESS_SIZE:0]   r_ptr,
    input  logic [ADDRESS_SIZE:0]   w_afull_thresh,
    input  logic                    w_ovf_clr,
    output logic                    w_accept,
    output logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE-1:0] w_addr,
    output logic                    w_full,
    output logic                    w_almost_full,
    output logic [ADDRESS_SIZE:0]   w_level,
    output logic                    w_overflow
);

    localparam int A = ADDRESS_SIZE;
    localparam int W = ADDRESS_SIZE + 1;
    localparam logic [W-1:0] DEPTH = {1'b1, {A{1'b0}}};

    logic [W-1:0] w_bin_q,   w_bin_d;
    logic [W-1:0] w_ptr_q,   w_ptr_d;
    logic [A-1:0] w_addr_q,  w_addr_d;
    logic         w_full_q,  w_full_d;
    logic         w_afull_q, w_afull_d;
    logic [W-1:0] w_level_q, w_level_d;
    logic         w_ovf_q,   w_ovf_d;
    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] sync_d [SYNC_STAGES];

    logic [W-1:0] w_bnext;
    logic [W-1:0] w_gnext;
    logic [W-1:0] wq_rptr;
    logic [W-1:0] wq_rbin;
    logic [W-1:0] thr;
    logic [W-1:0] full_pattern;

    // Next-state logic: pointer advance, Gray conversion, level and flags.
    // The full test compares against the synchronised read pointer with its
    // top two Gray bits inverted, which means "exactly one lap ahead".
    always_comb begin
        w_accept = w_en & ~w_full_q;
        w_bnext  = w_bin_q + {{A{1'b0}}, w_accept};
        w_gnext  = w_bnext ^ (w_bnext >> 1);

        wq_rptr = sync_q[SYNC_STAGES-1];
        wq_rbin = '0;
        for (int i = 0; i < W; i++) begin
            wq_rbin[i] = ^(wq_rptr >> i);
        end

        thr          = (w_afull_thresh > DEPTH) ? DEPTH : w_afull_thresh;
        full_pattern = {~wq_rptr[A:A-1], wq_rptr[A-2:0]};

        w_bin_d   = w_bnext;
        w_ptr_d   = w_gnext;
        w_addr_d  = w_bnext[A-1:0];
        w_full_d  = (w_gnext == full_pattern);
        w_level_d = w_bnext - wq_rbin;
        w_afull_d = (w_level_d >= thr);
        w_ovf_d   = (w_en & w_full_q) | (w_ovf_q & ~w_ovf_clr);

        sync_d[0] = r_ptr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // All state, including the read-pointer synchroniser, clears on reset.
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            w_bin_q   <= '0;
            w_ptr_q   <= '0;
            w_addr_q  <= '0;
            w_full_q  <= 1'b0;
            w_afull_q <= 1'b0;
            w_level_q <= '0;
            w_ovf_q   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            w_bin_q   <= w_bin_d;
            w_ptr_q   <= w_ptr_d;
            w_addr_q  <= w_addr_d;
            w_full_q  <= w_full_d;
            w_afull_q <= w_afull_d;
            w_level_q <= w_level_d;
            w_ovf_q   <= w_ovf_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign w_ptr         = w_ptr_q;
    assign w_addr        = w_addr_q;
    assign w_full        = w_full_q;
    assign w_almost_full = w_afull_q;
    assign w_level       = w_level_q;
    assign w_overflow    = w_ovf_q;

endmodule

// File: tb/tb_w_clk_ctrl_prog.sv
// Bench for w_clk_ctrl_prog with a 3-bit address and two synchroniser stages.
// The reference tracks absolute write and read counts and derives every
// expected output from them.
module tb_w_clk_ctrl_prog;

   localparam int AS    = 3;
   localparam int SS    = 2;
   localparam int DEPTH = 8;
   localparam int LAP   = 16;

   logic          w_clk;
   logic          wrst_n;
   logic          w_en;
   logic [AS:0]   r_ptr;
   logic [AS:0]   w_afull_thresh;
   logic          w_ovf_clr;
   logic          w_accept;
   logic [AS:0]   w_ptr;
   logic [AS-1:0] w_addr;
   logic          w_full;
   logic          w_almost_full;
   logic [AS:0]   w_level;
   logic          w_overflow;

   int testCount;
   int failCount;

   int wrTotal;
   int rdCount;
   int seenHist [SS];
   int levelM;
   bit fullM;
   bit afullM;
   bit ovfM;

   int gseq [9];

   w_clk_ctrl_prog #(
      .ADDRESS_SIZE(AS),
      .SYNC_STAGES (SS)
   ) dut (
      .w_clk         (w_clk),
      .wrst_n        (wrst_n),
      .w_en          (w_en),
      .r_ptr         (r_ptr),
      .w_afull_thresh(w_afull_thresh),
      .w_ovf_clr     (w_ovf_clr),
      .w_accept      (w_accept),
      .w_ptr         (w_ptr),
      .w_addr        (w_addr),
      .w_full        (w_full),
      .w_almost_full (w_almost_full),
      .w_level       (w_level),
      .w_overflow    (w_overflow)
   );

   // Free-running write clock, period 10.
   initial begin
      w_clk = 1'b0;
      forever #5 w_clk = ~w_clk;
   end

   function automatic logic [AS:0] toGray(input int count);
      logic [AS:0] b;
      b = count[AS:0];
      return b ^ (b >> 1);
   endfunction

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference step: one write-clock edge in terms of counts.
   task automatic modelEdge();
      int seen;
      int thrc;
      bit acc;
      acc  = w_en && !fullM;
      ovfM = (w_en && fullM) || (ovfM && !w_ovf_clr);
      wrTotal += acc ? 1 : 0;
      seen = seenHist[SS-1];
      for (int i = SS-1; i > 0; i--) seenHist[i] = seenHist[i-1];
      seenHist[0] = rdCount;
      thrc   = (int'(w_afull_thresh) > DEPTH) ? DEPTH : int'(w_afull_thresh);
      levelM = wrTotal - seen;
      fullM  = (levelM == DEPTH);
      afullM = (levelM >= thrc);
   endtask

   task automatic checkOutput();
      compare("w_ptr",         w_ptr,         toGray(wrTotal));
      compare("w_addr",        w_addr,        wrTotal % DEPTH);
      compare("w_full",        w_full,        fullM);
      compare("w_almost_full", w_almost_full, afullM);
      compare("w_level",       w_level,       levelM);
      compare("w_overflow",    w_overflow,    ovfM);
   endtask

   // Drive one cycle of inputs, check the combinational accept, then the
   // registered outputs just after the edge.
   task automatic applyStimulus(input bit en, input bit clr, input int rc);
      @(negedge w_clk);
      w_en      = en;
      w_ovf_clr = clr;
      rdCount   = rc;
      r_ptr     = toGray(rc);
      #1;
      compare("w_accept", w_accept, en && !fullM);
      @(posedge w_clk);
      modelEdge();
      #1;
      checkOutput();
   endtask

   // Reset asserted between edges; outputs must clear before the next edge.
   task automatic doReset(input logic [AS:0] thr);
      @(negedge w_clk);
      #2;
      wrst_n = 1'b0;
      #1;
      compare("rst_w_ptr",    w_ptr,         0);
      compare("rst_w_addr",   w_addr,        0);
      compare("rst_w_full",   w_full,        0);
      compare("rst_w_afull",  w_almost_full, 0);
      compare("rst_w_level",  w_level,       0);
      compare("rst_w_ovf",    w_overflow,    0);
      compare("rst_w_accept", w_accept,      w_en);
      w_en = 1'b0;
      w_ovf_clr = 1'b0;
      w_afull_thresh = thr;
      rdCount = 0;
      r_ptr = '0;
      wrTotal = 0;
      for (int i = 0; i < SS; i++) seenHist[i] = 0;
      levelM = 0;
      fullM = 0;
      afullM = 0;
      ovfM = 0;
      @(negedge w_clk);
      #2;
      wrst_n = 1'b1;
   endtask

   initial begin
      int rc;
      testCount = 0;
      failCount = 0;
      gseq = '{0, 1, 3, 2, 6, 7, 5, 4, 12};
      wrst_n = 1'b0;
      w_en = 1'b1;
      w_ovf_clr = 1'b0;
      w_afull_thresh = 4'd6;
      r_ptr = '0;
      rdCount = 0;
      wrTotal = 0;
      for (int i = 0; i < SS; i++) seenHist[i] = 0;
      levelM = 0; fullM = 0; afullM = 0; ovfM = 0;
      #3;
      compare("init_w_accept", w_accept, 1);
      doReset(4'd6);

      // Fill from empty with the reader parked at zero.
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(1, 0, 0);
         compare("s1_gray", w_ptr, gseq[(i > 8) ? 8 : i]);
         compare("s1_afull", w_almost_full, i >= 6);
      end
      compare("s1_full", w_full, 1);
      compare("s1_level", w_level, 8);

      // Overflow sets, holds, clears, and a coincident set wins over clear.
      applyStimulus(1, 0, 0);
      compare("s2_ovf_set", w_overflow, 1);
      applyStimulus(0, 0, 0);
      compare("s2_ovf_hold", w_overflow, 1);
      applyStimulus(0, 1, 0);
      compare("s2_ovf_clr", w_overflow, 0);
      applyStimulus(1, 1, 0);
      compare("s2_ovf_both", w_overflow, 1);
      applyStimulus(0, 1, 0);

      // Reader drains two entries; the write side sees it on the third edge.
      applyStimulus(0, 0, 2);
      compare("s3_full_e1", w_full, 1);
      applyStimulus(0, 0, 2);
      compare("s3_full_e2", w_full, 1);
      applyStimulus(0, 0, 2);
      compare("s3_full_e3", w_full, 0);
      compare("s3_level_e3", w_level, 6);
      compare("s3_afull_e3", w_almost_full, 1);

      // Lap wrap with the reader trailing one entry per cycle.
      rc = 2;
      for (int i = 0; i < 24; i++) begin
         if (rc < wrTotal) rc++;
         applyStimulus(1, 0, rc);
         if (wrTotal % LAP == 0) begin
            compare("s4_wrap_ptr", w_ptr, 0);
            compare("s4_wrap_addr", w_addr, 0);
         end
      end

      // Mid-operation reset from a level of five.
      doReset(4'd6);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
      compare("s5_level", w_level, 5);
      doReset(4'd6);
      compare("s5_addr_first", w_addr, 0);
      applyStimulus(1, 0, 0);
      compare("s5_addr_after", w_addr, 1);

      // Threshold zero and an over-range threshold.
      doReset(4'd0);
      applyStimulus(0, 0, 0);
      compare("s6_thr0_afull", w_almost_full, 1);
      doReset(4'd15);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1, 0, 0);
         compare("s6_clamp", w_almost_full, w_full);
      end
      compare("s6_clamp_full", w_full, 1);

      // Randomised traffic with a randomly paced reader.
      doReset(4'($urandom_range(0, 10)));
      rc = 0;
      for (int i = 0; i < 400; i++) begin
         if (rc < wrTotal && $urandom_range(0, 2) != 0) rc++;
         applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), rc);
         if (i == 200) begin
            doReset(4'($urandom_range(0, 10)));
            rc = 0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
